// File: rtl/osd_regaccess_mux.sv
// Packet-level 2:1 merger of register-access responses and bypass traffic onto one registered DII output.
// Define OSD_REGACCESS_MUX_RR_EN for round-robin arbitration; otherwise in_reg has fixed priority.
module osd_regaccess_mux (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_reg_data,
   input  logic        in_reg_last,
   input  logic        in_reg_valid,
   output logic        in_reg_ready,
   input  logic [15:0] in_bypass_data,
   input  logic        in_bypass_last,
   input  logic        in_bypass_valid,
   output logic        in_bypass_ready,
   output logic [15:0] out_data,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {IDLE, REG, BYP} state_t;

   state_t      state;
   state_t      state_next;
   logic        grant_reg;
   logic        grant_byp;
   logic        can_accept;
   logic        accept;
   logic [15:0] acc_data;
   logic        acc_last;
`ifdef OSD_REGACCESS_MUX_RR_EN
   logic        rr_byp_first;
`endif

   always_comb begin
      grant_reg  = 1'b0;
      grant_byp  = 1'b0;
      state_next = state;

      case (state)
         IDLE: begin
            if (in_reg_valid && in_bypass_valid) begin
`ifdef OSD_REGACCESS_MUX_RR_EN
               grant_reg = !rr_byp_first;
               grant_byp = rr_byp_first;
`else
               grant_reg = 1'b1;
`endif
            end else if (in_reg_valid) begin
               grant_reg = 1'b1;
            end else if (in_bypass_valid) begin
               grant_byp = 1'b1;
            end
         end
         REG:     grant_reg = 1'b1;
         BYP:     grant_byp = 1'b1;
         default: state_next = IDLE;
      endcase

      // Readies are held low while reset is asserted, even if inputs are valid
      can_accept      = rst && (!out_valid || out_ready);
      in_reg_ready    = grant_reg && can_accept;
      in_bypass_ready = grant_byp && can_accept;
      accept          = (in_reg_ready && in_reg_valid) || (in_bypass_ready && in_bypass_valid);
      acc_data        = grant_reg ? in_reg_data : in_bypass_data;
      acc_last        = grant_reg ? in_reg_last : in_bypass_last;

      if (accept) begin
         if (acc_last)
            state_next = IDLE;
         else
            state_next = grant_reg ? REG : BYP;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= 16'h0000;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= acc_data;
         out_last  <= acc_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef OSD_REGACCESS_MUX_RR_EN
   // Pointer flips to favour the other source whenever a new packet is granted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rr_byp_first <= 1'b0;
      else if (state == IDLE && accept)
         rr_byp_first <= grant_reg;
   end
`endif

endmodule
